fifo2uart: RTL and testbench
============================

Name: fifo2uart

Overview:
- Transmit-side counterpart of uart2fifo. On a start pulse it drains a fixed number of bytes from the shared byte FIFO and presents them to uart_tx as one framed packet.
- Frame format: HEAD0, HEAD1, LEN, LEN payload bytes, then an optional XOR checksum.
- Sits between the FIFO read port and the uart_tx_inst tx_data/valid/ready handshake, on sys_clk.

Parameters:
- HEAD0, 8'hAA, first header byte.
- HEAD1, 8'h55, second header byte.
- CHK_EN, 1, 1 = append checksum byte; 0 = frame ends after the last payload byte.

Ports:
- clk  input  1  system clock (sys_clk, 50 MHz).
- rst  input  1  synchronous reset, active-high.
- start  input  1  one-cycle request to send a frame; sampled only in IDLE.
- data_len  input  8  payload byte count, latched on accepted start; 0 is legal.
- busy  output  1  high from the cycle after start is accepted until DONE exits.
- done  output  1  one-cycle pulse when the last frame byte is accepted by uart_tx.
- fifo_empty  input  1  FIFO empty flag.
- fifo_rxen  output  1  FIFO read enable, one-cycle pulse per byte.
- fifo_rxd  input  8  FIFO read data, valid exactly one cycle after fifo_rxen (standard-mode FIFO).
- uart_txd  output  8  byte to uart_tx.
- uart_txdv  output  1  byte valid to uart_tx.
- uart_txdr  input  1  uart_tx ready; a byte transfers on the cycle uart_txdv && uart_txdr.

Behaviour:
- Reset, applied in any state including mid-frame:
  - State returns to IDLE; the FIFO is not drained and the remaining bytes stay in it.
  - busy=0, done=0, fifo_rxen=0, uart_txdv=0, uart_txd=8'h00.
  - Latched length, byte counter and checksum are cleared.
- State machine: IDLE, HDR0, HDR1, LEN, RD, RDW, DATA, CHK, DONE.
- IDLE: when start=1, latch len=data_len, clear chk=0, go to HDR0. Otherwise hold.
- Send rule for HDR0, HDR1, LEN, DATA and CHK:
  - uart_txdv=1 with uart_txd registered.
  - uart_txd must stay stable while uart_txdv=1 and uart_txdr=0.
  - Advance on the transfer cycle; uart_txdv drops the cycle after the transfer.
  - No byte is presented twice.
- HDR0 sends HEAD0, then HDR1 sends HEAD1.
- LEN sends len and sets chk=len.
  - If len=0, go to CHK when CHK_EN=1, otherwise to DONE.
  - If len>0, go to RD.
- RD: if fifo_empty=1, wait indefinitely with fifo_rxen=0. Otherwise pulse fifo_rxen for one cycle and go to RDW.
- RDW: capture fifo_rxd into uart_txd, go to DATA. fifo_rxen=0 here, so there is never more than one outstanding read.
- DATA: on transfer, chk ^= byte and cnt+1.
  - If cnt+1==len, go to CHK when CHK_EN=1, otherwise to DONE.
  - Else go back to RD.
- CHK sends chk, the XOR of the LEN byte and all payload bytes, then goes to DONE.
- DONE: done=1 for exactly one cycle, busy=0 in the same cycle, return to IDLE.
- Start handling:
  - start asserted while busy is ignored.
  - start in the same cycle as DONE is ignored.
  - A new frame can begin on the cycle after DONE.
- Counter: cnt is 8 bits. len=255 sends 255 payload bytes with no wrap.
- Minimum payload byte period is 3 cycles: RD, RDW, DATA with uart_txdr already high. In practice uart_tx throttles to the baud rate.
- fifo_rxen is never asserted while fifo_empty=1. No underflow is possible.

Test Plan:
- Basic frame: reset; FIFO holds 8'h11, 8'h22, 8'h33; start with data_len=3; uart_txdr always 1 -> bytes AA 55 03 11 22 33 03 are transferred in order; exactly 3 fifo_rxen pulses; one done pulse; busy low afterwards.
- Zero length, CHK_EN=1: start with data_len=0 -> AA 55 00 00, then done; fifo_rxen never asserted. With CHK_EN=0 -> AA 55 00, then done.
- Backpressure: hold uart_txdr=0 for 10 cycles on each byte -> uart_txdv stays high and uart_txd stays stable for the whole stall; the byte sequence is unchanged from the basic frame; no duplicate bytes.
- FIFO underrun: start with data_len=2 and only 1 byte in the FIFO -> frame stalls in RD with fifo_rxen=0 and uart_txdv=0 after the first payload byte; writing 8'h5A resumes the frame; checksum = 02^first^5A.
- Start while busy: pulse start mid-frame with data_len=9 -> ignored; the frame completes with the original length; exactly one done pulse.
- Reset mid-frame: assert rst during the second payload byte -> next cycle all outputs are at reset values; a following start with data_len=1 sends a complete new frame beginning with AA.

Source files
------------

// File: rtl/fifo2uart.sv
// fifo2uart: drains a byte FIFO into uart_tx as one framed packet.
// Frame is HEAD0, HEAD1, LEN, payload, and an optional XOR checksum.
module fifo2uart #(
  parameter logic [7:0] HEAD0  = 8'hAA,
  parameter logic [7:0] HEAD1  = 8'h55,
  parameter bit         CHK_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data_len,
  output logic       busy,
  output logic       done,
  input  logic       fifo_empty,
  output logic       fifo_rxen,
  input  logic [7:0] fifo_rxd,
  output logic [7:0] uart_txd,
  output logic       uart_txdv,
  input  logic       uart_txdr
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_HDR0,
    S_HDR1,
    S_LEN,
    S_RD,
    S_RDW,
    S_DATA,
    S_CHK,
    S_DONE
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_len;
  logic [7:0] r_cnt;
  logic [7:0] r_chk;
  logic [7:0] r_txd;
  logic [7:0] w_cnt_nxt;
  logic       w_send;
  logic       w_xfer;
  logic       w_rd;
  logic       w_last;

  assign w_send = (r_state == S_HDR0) ||
                  (r_state == S_HDR1) ||
                  (r_state == S_LEN)  ||
                  (r_state == S_DATA) ||
                  (r_state == S_CHK);

  // Gated by rst so a reset cycle never drains the FIFO or hands off a byte.
  assign uart_txdv = w_send & ~rst;
  assign w_xfer    = uart_txdv & uart_txdr;
  assign w_rd      = (r_state == S_RD) & ~fifo_empty & ~rst;
  assign fifo_rxen = w_rd;

  assign w_cnt_nxt = r_cnt + 8'd1;
  assign w_last    = (w_cnt_nxt == r_len);

  assign uart_txd  = r_txd;
  assign done      = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE) && (r_state != S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_next = S_HDR0;
      end
      S_HDR0: begin
        if (w_xfer) w_next = S_HDR1;
      end
      S_HDR1: begin
        if (w_xfer) w_next = S_LEN;
      end
      S_LEN: begin
        if (w_xfer) begin
          if (r_len != 8'd0) w_next = S_RD;
          else w_next = CHK_EN ? S_CHK : S_DONE;
        end
      end
      S_RD: begin
        if (w_rd) w_next = S_RDW;
      end
      S_RDW: begin
        w_next = S_DATA;
      end
      S_DATA: begin
        if (w_xfer) begin
          if (!w_last) w_next = S_RD;
          else w_next = CHK_EN ? S_CHK : S_DONE;
        end
      end
      S_CHK: begin
        if (w_xfer) w_next = S_DONE;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // The next byte is loaded on the transfer edge, so uart_txd only
  // changes when uart_tx has just taken the current one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_len <= 8'd0;
      r_cnt <= 8'd0;
      r_chk <= 8'd0;
      r_txd <= 8'd0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_len <= data_len;
            r_cnt <= 8'd0;
            r_chk <= 8'd0;
            r_txd <= HEAD0;
          end
        end
        S_HDR0: begin
          if (w_xfer) r_txd <= HEAD1;
        end
        S_HDR1: begin
          if (w_xfer) r_txd <= r_len;
        end
        S_LEN: begin
          if (w_xfer) begin
            r_chk <= r_len;
            r_txd <= r_len;
          end
        end
        S_RDW: begin
          r_txd <= fifo_rxd;
        end
        S_DATA: begin
          if (w_xfer) begin
            r_chk <= r_chk ^ r_txd;
            r_cnt <= w_cnt_nxt;
            if (w_last) r_txd <= r_chk ^ r_txd;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo2uart.sv
// Scoreboard bench for fifo2uart: a FIFO model feeds the DUT and a
// monitor compares every uart_tx transfer against queued expectations.
module tb_fifo2uart;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] data_len;
  logic       busy;
  logic       done;
  logic       fifo_empty;
  logic       fifo_rxen;
  logic [7:0] fifo_rxd;
  logic [7:0] uart_txd;
  logic       uart_txdv;
  logic       uart_txdr;

  logic       start0;
  logic       busy0;
  logic       done0;
  logic       empty0 = 1'b1;
  logic       rxen0;
  logic [7:0] rxd0 = 8'h00;
  logic [7:0] txd0;
  logic       txdv0;
  logic       txdr0 = 1'b1;

  always #5 clk = ~clk;

  fifo2uart u_dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .data_len  (data_len),
    .busy      (busy),
    .done      (done),
    .fifo_empty(fifo_empty),
    .fifo_rxen (fifo_rxen),
    .fifo_rxd  (fifo_rxd),
    .uart_txd  (uart_txd),
    .uart_txdv (uart_txdv),
    .uart_txdr (uart_txdr)
  );

  fifo2uart #(.CHK_EN(1'b0)) u_dut0 (
    .clk       (clk),
    .rst       (rst),
    .start     (start0),
    .data_len  (data_len),
    .busy      (busy0),
    .done      (done0),
    .fifo_empty(empty0),
    .fifo_rxen (rxen0),
    .fifo_rxd  (rxd0),
    .uart_txd  (txd0),
    .uart_txdv (txdv0),
    .uart_txdr (txdr0)
  );

  logic [7:0] mem [0:1023];
  int         wp = 0;
  int         rp = 0;
  logic [7:0] exp_q [$];
  logic [7:0] exp0_q [$];
  logic [7:0] tb_chk;
  int n_tests = 0;
  int n_fail = 0;
  int rxen_cnt = 0;
  int done_cnt = 0;
  int done0_cnt = 0;
  int bp_mode = 0;
  int d0;
  int r0;

  assign fifo_empty = (wp == rp);

  task automatic check(input bit ok, input string name,
                       input int act, input int req);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Standard-mode FIFO: data appears the cycle after the read enable.
  initial begin
    fifo_rxd = 8'h00;
    forever begin
      @(posedge clk);
      if (fifo_rxen) begin
        fifo_rxd <= mem[rp];
        rp <= rp + 1;
      end
    end
  end

  // uart_tx ready: always high, or stalled 10 cycles per byte.
  initial begin
    int stall;
    stall = 0;
    uart_txdr = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode == 0) begin
        uart_txdr = 1'b1;
        stall = 0;
      end else if (uart_txdv && stall < 10) begin
        uart_txdr = 1'b0;
        stall++;
      end else if (uart_txdv) begin
        uart_txdr = 1'b1;
        stall = 0;
      end else begin
        uart_txdr = 1'b0;
        stall = 0;
      end
    end
  end

  // Monitor: pops the scoreboard on every transfer.
  initial begin
    logic       prev_stall;
    logic [7:0] prev_txd;
    logic [7:0] e;
    prev_stall = 1'b0;
    prev_txd = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (fifo_rxen) begin
          rxen_cnt++;
          check(!fifo_empty, "rxen_on_empty", int'(fifo_empty), 0);
        end
        if (done) done_cnt++;
        if (done0) done0_cnt++;
        if (prev_stall)
          check(uart_txdv && uart_txd == prev_txd, "stall_stable",
                int'({uart_txdv, uart_txd}), int'({1'b1, prev_txd}));
        if (uart_txdv && uart_txdr) begin
          if (exp_q.size() == 0) begin
            check(1'b0, "extra_byte", int'(uart_txd), -1);
          end else begin
            e = exp_q.pop_front();
            check(uart_txd == e, "tx_byte", int'(uart_txd), int'(e));
          end
        end
        if (txdv0 && txdr0) begin
          if (exp0_q.size() == 0) begin
            check(1'b0, "extra_byte_nochk", int'(txd0), -1);
          end else begin
            e = exp0_q.pop_front();
            check(txd0 == e, "tx_byte_nochk", int'(txd0), int'(e));
          end
        end
        check(!rxen0, "nochk_rxen", int'(rxen0), 0);
        prev_stall = uart_txdv && !uart_txdr;
        prev_txd = uart_txd;
      end
    end
  end

  task automatic push(input logic [7:0] b);
    mem[wp] = b;
    wp = wp + 1;
  endtask

  task automatic begin_frame(input logic [7:0] len);
    tb_chk = len;
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'h55);
    exp_q.push_back(len);
  endtask

  task automatic payload(input logic [7:0] b);
    push(b);
    exp_q.push_back(b);
    tb_chk = tb_chk ^ b;
  endtask

  task automatic end_frame();
    exp_q.push_back(tb_chk);
  endtask

  task automatic kick(input logic [7:0] len);
    d0 = done_cnt;
    r0 = rxen_cnt;
    @(posedge clk);
    #1;
    start = 1'b1;
    data_len = len;
    @(posedge clk);
    #1;
    start = 1'b0;
    check(busy == 1'b1, "busy_after_start", int'(busy), 1);
  endtask

  task automatic finish_frame(input string name, input int exp_rxen);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(posedge clk);
      if (done_cnt != d0) begin
        ok = 1'b1;
        break;
      end
    end
    check(ok, {name, "_timeout"}, int'(ok), 1);
    repeat (3) @(posedge clk);
    #1;
    check(done_cnt - d0 == 1, {name, "_done_cnt"}, done_cnt - d0, 1);
    check(rxen_cnt - r0 == exp_rxen, {name, "_rxen_cnt"},
          rxen_cnt - r0, exp_rxen);
    check(exp_q.size() == 0, {name, "_missing"}, exp_q.size(), 0);
    check(busy == 1'b0, {name, "_busy_end"}, int'(busy), 0);
    exp_q.delete();
  endtask

  task automatic check_reset_outs(input string name);
    check(busy == 1'b0, {name, "_busy"}, int'(busy), 0);
    check(done == 1'b0, {name, "_done"}, int'(done), 0);
    check(fifo_rxen == 1'b0, {name, "_rxen"}, int'(fifo_rxen), 0);
    check(uart_txdv == 1'b0, {name, "_txdv"}, int'(uart_txdv), 0);
    check(uart_txd == 8'h00, {name, "_txd"}, int'(uart_txd), 0);
  endtask

  initial begin
    bit ok;
    rst = 1'b1;
    start = 1'b0;
    start0 = 1'b0;
    data_len = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outs("reset");
    rst = 1'b0;

    // Basic frame: AA 55 03 11 22 33 03
    begin_frame(8'd3);
    payload(8'h11);
    payload(8'h22);
    payload(8'h33);
    end_frame();
    kick(8'd3);
    finish_frame("basic", 3);

    // Zero length with checksum: AA 55 00 00
    begin_frame(8'd0);
    end_frame();
    kick(8'd0);
    finish_frame("zero", 0);

    // Zero length without checksum: AA 55 00
    exp0_q.push_back(8'hAA);
    exp0_q.push_back(8'h55);
    exp0_q.push_back(8'h00);
    d0 = done0_cnt;
    @(posedge clk);
    #1;
    start0 = 1'b1;
    data_len = 8'd0;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (done0_cnt != d0) begin
        ok = 1'b1;
        break;
      end
    end
    check(ok, "nochk_timeout", int'(ok), 1);
    repeat (3) @(posedge clk);
    #1;
    check(done0_cnt - d0 == 1, "nochk_done_cnt", done0_cnt - d0, 1);
    check(exp0_q.size() == 0, "nochk_missing", exp0_q.size(), 0);

    // Backpressure: 10 stall cycles per byte
    bp_mode = 1;
    begin_frame(8'd3);
    payload(8'h11);
    payload(8'h22);
    payload(8'h33);
    end_frame();
    kick(8'd3);
    finish_frame("bp", 3);
    bp_mode = 0;

    // Underrun: one byte present, second arrives late; chk = 02^3C^5A = 64
    begin_frame(8'd2);
    payload(8'h3C);
    kick(8'd2);
    repeat (20) @(posedge clk);
    #1;
    check(uart_txdv == 1'b0, "under_txdv", int'(uart_txdv), 0);
    check(fifo_rxen == 1'b0, "under_rxen", int'(fifo_rxen), 0);
    check(busy == 1'b1, "under_busy", int'(busy), 1);
    check(exp_q.size() == 0, "under_sent", exp_q.size(), 0);
    payload(8'h5A);
    end_frame();
    check(tb_chk == 8'h64, "under_model_chk", int'(tb_chk), 'h64);
    finish_frame("under", 2);

    // Start while busy is ignored
    begin_frame(8'd2);
    payload(8'h0A);
    payload(8'h0B);
    end_frame();
    kick(8'd2);
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1;
    data_len = 8'd9;
    @(posedge clk);
    #1;
    start = 1'b0;
    finish_frame("busy_start", 2);

    // Maximum length: 255 payload bytes, counter must not wrap
    begin_frame(8'd255);
    for (int i = 0; i < 255; i++) payload(8'(i));
    end_frame();
    kick(8'd255);
    finish_frame("len255", 255);

    // Reset during the second payload byte; byte 03 stays in the FIFO
    begin_frame(8'd3);
    payload(8'h01);
    payload(8'h02);
    payload(8'h03);
    kick(8'd3);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (uart_txdv && uart_txd == 8'h02) begin
        ok = 1'b1;
        break;
      end
    end
    check(ok, "rst_wait_timeout", int'(ok), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outs("midrst");
    exp_q.delete();
    rst = 1'b0;
    begin_frame(8'd1);
    exp_q.push_back(8'h03);
    tb_chk = tb_chk ^ 8'h03;
    end_frame();
    kick(8'd1);
    finish_frame("after_rst", 1);
    check(fifo_empty == 1'b1, "fifo_drained", int'(fifo_empty), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
